seg_scan_ctrl: RTL and testbench

- Parametrised N-digit seven-segment scan controller, clocked from the system clock.
- An internal prescaler times each digit slot. Per-digit enable mask: disabled digits are skipped. Optional PWM brightness dimming.
- Emits a frame-start strobe. Drives the digit-select bus into the segment-data mux and the one-hot digit-drive lines to the display.

---
 rtl/seg_scan_pkg.sv | 44 ++++
 rtl/seg_scan_prescaler.sv | 51 +++++
 rtl/seg_scan_ctrl.sv | 82 ++++++++
 tb/tb_seg_scan_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package seg_scan_pkg;

    localparam int NUM_DIGITS_DEF = 4;
    localparam int PRESCALE_DEF   = 50000;
    localparam int DIM_BITS_DEF   = 3;
    localparam int MAX_DIGITS     = 16;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Next enabled index above cur, wrapping; cur itself if it is the only one
    function automatic logic [3:0] next_idx(
        input logic [15:0] en,
        input int          n,
        input logic [3:0]  cur
    );
        logic [3:0] res;
        logic       found;
        int         idx;
        res   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_DIGITS; k++) begin
            idx = int'(cur) + k;
            if (idx >= n) idx = idx - n;
            if (k <= n && !found && en[idx[3:0]]) begin
                res   = idx[3:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] lowest_idx(input logic [15:0] en);
        logic [3:0] res;
        res = '0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (en[i]) res = 4'(i);
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// Slot timer: prescale counter plus brightness phase counter.
// Phase counter exists only when SEG_SCAN_DIM_EN is defined.
module seg_scan_prescaler
    import seg_scan_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int DIM_BITS = DIM_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    output logic                phase_tick,
    output logic                slot_end,
    output logic [DIM_BITS-1:0] phase
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    assign phase_tick = (pre_cnt == PRE_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (phase_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

`ifdef SEG_SCAN_DIM_EN
    logic [DIM_BITS-1:0] phase_q;

    assign phase    = phase_q;
    assign slot_end = phase_tick && (phase_q == '1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
        end else if (phase_tick) begin
            phase_q <= phase_q + DIM_BITS'(1);
        end
    end
`else
    assign phase    = '0;
    assign slot_end = phase_tick;
`endif

endmodule

// File: rtl/seg_scan_ctrl.sv
// N-digit seven-segment scan controller with enable mask and frame strobe.
// Optional PWM dimming is built when SEG_SCAN_DIM_EN is defined.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int PRESCALE   = PRESCALE_DEF,
    parameter int DIM_BITS   = DIM_BITS_DEF,
    localparam int SEL_W     = sel_width(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic [DIM_BITS-1:0]   brightness,
    output logic [SEL_W-1:0]      sel,
    output logic [NUM_DIGITS-1:0] cat,
    output logic                  frame_start
);

    logic                  phase_tick;
    logic                  slot_end;
    logic [DIM_BITS-1:0]   phase;
    logic [SEL_W-1:0]      cur;
    logic [SEL_W-1:0]      nxt;
    logic                  first_q;
    logic [15:0]           en16;
    logic                  lit;
    logic                  frame_d;
    logic [NUM_DIGITS-1:0] cat_d;
    logic                  unused_bits;

    seg_scan_prescaler #(
        .PRESCALE (PRESCALE),
        .DIM_BITS (DIM_BITS)
    ) u_pre (
        .clk        (clk),
        .reset      (reset),
        .phase_tick (phase_tick),
        .slot_end   (slot_end),
        .phase      (phase)
    );

`ifdef SEG_SCAN_DIM_EN
    assign unused_bits = phase_tick;
`else
    assign unused_bits = ^{phase_tick, phase, brightness};
`endif

    // cur is the digit for the cycle being entered; sel is its registered copy
    always_comb begin
        en16 = 16'(digit_en);
`ifdef SEG_SCAN_DIM_EN
        lit = en16[4'(cur)] && (phase <= brightness);
`else
        lit = en16[4'(cur)];
`endif
        cat_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cat_d[i] = lit && (int'(cur) == NUM_DIGITS - 1 - i);
        end
        frame_d = first_q && (|digit_en)
                  && (4'(cur) == lowest_idx(en16));
        nxt = SEL_W'(next_idx(en16, NUM_DIGITS, 4'(cur)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur         <= '0;
            first_q     <= 1'b1;
            sel         <= '0;
            cat         <= '0;
            frame_start <= 1'b0;
        end else begin
            sel         <= cur;
            cat         <= cat_d;
            frame_start <= frame_d;
            first_q     <= slot_end;
            if (slot_end) cur <= nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (4 digits, PRESCALE=2, DIM_BITS=2).
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int PS = 2;
    localparam int DB = 2;
`ifdef SEG_SCAN_DIM_EN
    localparam int SLOT = PS * 4;
    localparam int LIT1 = 2 * PS;
    localparam int LIT0 = PS;
`else
    localparam int SLOT = PS;
    localparam int LIT1 = SLOT;
    localparam int LIT0 = SLOT;
`endif
    localparam int RCYC = (SLOT > 2) ? 5 : 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [ND-1:0] digit_en = 4'b1111;
    logic [DB-1:0] brightness = 2'd3;
    logic [1:0]    sel;
    logic [ND-1:0] cat;
    logic          frame_start;

    int vectors = 0;
    int miss = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .PRESCALE   (PS),
        .DIM_BITS   (DB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digit_en    (digit_en),
        .brightness  (brightness),
        .sel         (sel),
        .cat         (cat),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miss++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ncyc cycles of a slot at digit s, lit for the first nlit cycles
    task automatic run_slot(input int s, input int nlit, input bit fs,
                            input int ncyc);
        logic [3:0] oh;
        logic [3:0] one;
        one = 4'b1000;
        oh  = one >> s;
        for (int j = 0; j < ncyc; j++) begin
            step();
            chk("sel", 16'(sel), 16'(s));
            chk("cat", 16'(cat), (j < nlit) ? 16'(oh) : 16'h0);
            chk("frame_start", 16'(frame_start), 16'(fs && j == 0));
        end
    endtask

    initial begin
        // reset and basic scan
        #23;
        chk("rst_sel", 16'(sel), 16'h0);
        chk("rst_cat", 16'(cat), 16'h0);
        chk("rst_fs", 16'(frame_start), 16'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        run_slot(0, SLOT, 1, SLOT);
        run_slot(1, SLOT, 0, SLOT);
        run_slot(2, SLOT, 0, SLOT);
        run_slot(3, SLOT, 0, SLOT);
        run_slot(0, SLOT, 1, SLOT);

        // mask skipping
        digit_en = 4'b1010;
        run_slot(1, SLOT, 1, SLOT);
        run_slot(3, SLOT, 0, SLOT);
        run_slot(1, SLOT, 1, SLOT);
        run_slot(3, SLOT, 0, SLOT);

        // dimming
        digit_en   = 4'b1111;
        brightness = 2'd1;
        run_slot(1, LIT1, 0, SLOT);
        run_slot(2, LIT1, 0, SLOT);
        brightness = 2'd0;
        run_slot(3, LIT0, 0, SLOT);

        // all disabled
        digit_en = 4'b0000;
        run_slot(0, 0, 0, SLOT);
        run_slot(0, 0, 0, SLOT);
        digit_en   = 4'b1111;
        brightness = 2'd3;
        run_slot(0, SLOT, 1, SLOT);

        // mid-slot disable of the current digit
        run_slot(1, SLOT, 0, SLOT / 2);
        digit_en = 4'b1101;
        run_slot(1, 0, 0, SLOT / 2);
        run_slot(2, SLOT, 0, RCYC);

        // asynchronous reset mid-slot
        #2 reset = 1'b0;
        #1;
        chk("async_sel", 16'(sel), 16'h0);
        chk("async_cat", 16'(cat), 16'h0);
        chk("async_fs", 16'(frame_start), 16'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        run_slot(0, SLOT, 1, SLOT);
        run_slot(2, SLOT, 0, SLOT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
